// File: rtl/mipi_phy_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mipi_phy_ctrl_pkg
// Shared definitions for the MIPI PHY bring-up controller: FSM state
// encoding (3 bits, values 0-6 are visible on the state port) and the
// default timing constants used as parameter defaults by the top level.
// -----------------------------------------------------------------------------
package mipi_phy_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_MMCM_RST  = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_PHY_RST   = 3'd3,
    ST_SEARCH    = 3'd4,
    ST_LINKED    = 3'd5,
    ST_FAIL      = 3'd6
  } state_t;

  localparam int DEF_CNT_W           = 24;
  localparam int DEF_MMCM_RST_CYCLES = 64;
  localparam int DEF_LOCK_TIMEOUT    = 65536;
  localparam int DEF_PHY_RST_CYCLES  = 16;
  localparam int DEF_SEARCH_TIMEOUT  = 1048576;
  localparam int DEF_LINK_TIMEOUT    = 4194304;
  localparam int DEF_MAX_RETRIES     = 8;

endpackage

// File: rtl/mipi_sync2.sv
// -----------------------------------------------------------------------------
// mipi_sync2
// Two-flop synchronizer bringing a single asynchronous level into the clk
// domain. Both stages clear on reset so the output starts low.
//   clk    : destination clock
//   resetb : async active-low reset
//   d      : asynchronous input level
//   q      : synchronized level (2 clk latency)
// -----------------------------------------------------------------------------
module mipi_sync2 (
  input  logic clk,
  input  logic resetb,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: non-blocking assignments keep meta and q as two distinct stages;
  // blocking ones would let d fall straight through to q in one edge.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/mipi_phy_ctrl.sv
// -----------------------------------------------------------------------------
// mipi_phy_ctrl
// Bring-up and supervision controller for a single-lane MIPI deserializer
// PHY. Sequences MMCM reset and PHY reset, programs the LP-stall period,
// searches for packet activity (optionally flipping lane polarity once) and
// retrains on lock loss or prolonged link silence.
//   clk, resetb      : system clock, async active-low reset
//   enable           : 1 = train and hold link, 0 = hold PHY in reset
//   auto_polarity    : allow one polarity flip per search
//   cfg_polarity     : initial md_polarity
//   cfg_tx_period    : LP-stall period programmed into the PHY
//   locked, phy_we   : asynchronous status from the PHY
//   mmcm_reset, phy_resetb, md_polarity, mipi_tx_period : PHY controls
//   link_up, fail, lock_lost, retry_count, state       : status
// -----------------------------------------------------------------------------
module mipi_phy_ctrl
  import mipi_phy_ctrl_pkg::*;
#(
  parameter int CNT_W           = DEF_CNT_W,
  parameter int MMCM_RST_CYCLES = DEF_MMCM_RST_CYCLES,
  parameter int LOCK_TIMEOUT    = DEF_LOCK_TIMEOUT,
  parameter int PHY_RST_CYCLES  = DEF_PHY_RST_CYCLES,
  parameter int SEARCH_TIMEOUT  = DEF_SEARCH_TIMEOUT,
  parameter int LINK_TIMEOUT    = DEF_LINK_TIMEOUT,
  parameter int MAX_RETRIES     = DEF_MAX_RETRIES
) (
  input  logic       clk,
  input  logic       resetb,
  input  logic       enable,
  input  logic       auto_polarity,
  input  logic       cfg_polarity,
  input  logic [7:0] cfg_tx_period,
  input  logic       locked,
  input  logic       phy_we,
  output logic       mmcm_reset,
  output logic       phy_resetb,
  output logic       md_polarity,
  output logic [7:0] mipi_tx_period,
  output logic       link_up,
  output logic       fail,
  output logic       lock_lost,
  output logic [7:0] retry_count,
  output logic [2:0] state
);

  // Each timeout fires on the last cycle of its window, so a state whose
  // limit is N lasts exactly N cycles from entry.
  localparam logic [CNT_W-1:0] MMCM_LAST   = CNT_W'(MMCM_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] PHY_LAST    = CNT_W'(PHY_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] SEARCH_LAST = CNT_W'(SEARCH_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LINK_LAST   = CNT_W'(LINK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_t           cur;
  logic [CNT_W-1:0] cnt;
  logic             pol_flipped;
  logic             locked_s;
  logic             we_s;
  logic             we_prev;
  logic             activity;
  logic             last_retry;

  mipi_sync2 u_sync_locked (.clk(clk), .resetb(resetb), .d(locked), .q(locked_s));
  mipi_sync2 u_sync_we     (.clk(clk), .resetb(resetb), .d(phy_we), .q(we_s));

  // A packet holds we high for several PHY clocks, so one rising edge of the
  // synchronized level marks one packet.
  assign activity   = we_s & ~we_prev;
  assign last_retry = ({1'b0, retry_count} + 9'd1) == 9'(MAX_RETRIES);
  assign state      = cur;

  // Every state change restarts the shared timeout counter.
  task automatic goto(input state_t nxt);
    cur <= nxt;
    cnt <= '0;
  endtask

  // Full retrain from MMCM reset, or give up once the attempt budget is spent.
  task automatic retry();
    link_up     <= 1'b0;
    phy_resetb  <= 1'b0;
    mmcm_reset  <= 1'b1;
    pol_flipped <= 1'b0;
    if (last_retry) begin
      fail <= 1'b1;
      goto(ST_FAIL);
    end else begin
      if (retry_count != 8'hFF) retry_count <= retry_count + 8'd1;
      md_polarity <= cfg_polarity;
      goto(ST_MMCM_RST);
    end
  endtask

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      cur            <= ST_IDLE;
      cnt            <= '0;
      pol_flipped    <= 1'b0;
      we_prev        <= 1'b0;
      mmcm_reset     <= 1'b1;
      phy_resetb     <= 1'b0;
      md_polarity    <= 1'b0;
      mipi_tx_period <= 8'd0;
      link_up        <= 1'b0;
      fail           <= 1'b0;
      lock_lost      <= 1'b0;
      retry_count    <= 8'd0;
    end else begin
      we_prev   <= we_s;
      lock_lost <= 1'b0;
      if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);

      if (!enable) begin
        // Dropping enable overrides every other transition.
        goto(ST_IDLE);
        mmcm_reset <= 1'b1;
        phy_resetb <= 1'b0;
        link_up    <= 1'b0;
        fail       <= 1'b0;
      end else begin
        case (cur)
          ST_IDLE: begin
            md_polarity    <= cfg_polarity;
            mipi_tx_period <= cfg_tx_period;
            retry_count    <= 8'd0;
            pol_flipped    <= 1'b0;
            goto(ST_MMCM_RST);
          end
          ST_MMCM_RST: begin
            if (cnt == MMCM_LAST) begin
              mmcm_reset <= 1'b0;
              goto(ST_WAIT_LOCK);
            end
          end
          ST_WAIT_LOCK: begin
            if (locked_s)               goto(ST_PHY_RST);
            else if (cnt == LOCK_LAST)  retry();
          end
          ST_PHY_RST: begin
            if (cnt == PHY_LAST) begin
              phy_resetb <= 1'b1;
              goto(ST_SEARCH);
            end
          end
          ST_SEARCH: begin
            if (activity) begin
              link_up <= 1'b1;
              goto(ST_LINKED);
            end else if (!locked_s) begin
              retry();
            end else if (cnt == SEARCH_LAST) begin
              if (auto_polarity && !pol_flipped) begin
                // Polarity only changes while the PHY is held in reset.
                md_polarity <= ~md_polarity;
                pol_flipped <= 1'b1;
                phy_resetb  <= 1'b0;
                goto(ST_PHY_RST);
              end else begin
                retry();
              end
            end
          end
          ST_LINKED: begin
            if (!locked_s) begin
              lock_lost <= 1'b1;
              retry();
            end else if (activity) begin
              cnt <= '0;
            end else if (cnt == LINK_LAST) begin
              link_up     <= 1'b0;
              phy_resetb  <= 1'b0;
              pol_flipped <= 1'b0;
              goto(ST_PHY_RST);
            end
          end
          ST_FAIL: ;
          default: goto(ST_IDLE);
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mipi_phy_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mipi_phy_ctrl
// Self-checking bench for mipi_phy_ctrl with shortened timing parameters.
// -----------------------------------------------------------------------------
module tb_mipi_phy_ctrl;
  import mipi_phy_ctrl_pkg::*;

  localparam int MMCM_N   = 4;
  localparam int LOCK_N   = 32;
  localparam int PHYR_N   = 3;
  localparam int SEARCH_N = 50;
  localparam int LINK_N   = 100;
  localparam int RETRY_N  = 3;

  logic       clk = 1'b0;
  logic       resetb;
  logic       enable;
  logic       auto_polarity;
  logic       cfg_polarity;
  logic [7:0] cfg_tx_period;
  logic       locked;
  logic       phy_we;
  logic       mmcm_reset;
  logic       phy_resetb;
  logic       md_polarity;
  logic [7:0] mipi_tx_period;
  logic       link_up;
  logic       fail;
  logic       lock_lost;
  logic [7:0] retry_count;
  logic [2:0] state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  mipi_phy_ctrl #(
    .CNT_W(24), .MMCM_RST_CYCLES(MMCM_N), .LOCK_TIMEOUT(LOCK_N),
    .PHY_RST_CYCLES(PHYR_N), .SEARCH_TIMEOUT(SEARCH_N),
    .LINK_TIMEOUT(LINK_N), .MAX_RETRIES(RETRY_N)
  ) dut (
    .clk(clk), .resetb(resetb), .enable(enable), .auto_polarity(auto_polarity),
    .cfg_polarity(cfg_polarity), .cfg_tx_period(cfg_tx_period), .locked(locked),
    .phy_we(phy_we), .mmcm_reset(mmcm_reset), .phy_resetb(phy_resetb),
    .md_polarity(md_polarity), .mipi_tx_period(mipi_tx_period), .link_up(link_up),
    .fail(fail), .lock_lost(lock_lost), .retry_count(retry_count), .state(state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget, input string name);
    int n = 0;
    while (state !== st && n < budget) begin
      tick(1);
      n++;
    end
    check(name, 32'(state), 32'(st));
  endtask

  task automatic wait_leave_search(input int budget);
    int n = 0;
    while (state === ST_SEARCH && n < budget) begin
      tick(1);
      n++;
    end
  endtask

  task automatic do_reset();
    resetb = 1'b0; enable = 1'b0; locked = 1'b0; phy_we = 1'b0;
    auto_polarity = 1'b0; cfg_polarity = 1'b0; cfg_tx_period = 8'd0;
    tick(2);
    resetb = 1'b1;
    tick(1);
  endtask

  // Raise phy_we for at least 4 cycles; report cycles until link_up and the
  // cycle stamp at which it was seen.
  task automatic pulse_we(output int lat, output int t_link);
    phy_we = 1'b1;
    lat = 0;
    while (link_up !== 1'b1 && lat < 8) begin
      tick(1);
      lat++;
    end
    t_link = cyc;
    if (lat < 4) tick(4 - lat);
    phy_we = 1'b0;
  endtask

  task automatic bring_up(input logic pol, input logic ap, input logic [7:0] tx, input int lock_delay);
    cfg_polarity = pol; auto_polarity = ap; cfg_tx_period = tx;
    enable = 1'b1;
    wait_state(ST_WAIT_LOCK, 20, "bring_up.wait_lock");
    tick(lock_delay);
    locked = 1'b1;
    wait_state(ST_SEARCH, 20, "bring_up.search");
  endtask

  // Reference outcome of one training run from the link rules alone:
  // mode 0 = packet on the first polarity, 1 = packet only after a flip,
  // 2 = never any packet.
  function automatic void model(input bit pol, input bit ap, input int mode,
                                output bit exp_link, output bit exp_pol, output int exp_rc);
    exp_link = (mode == 0) || (mode == 1 && ap);
    exp_pol  = (exp_link && mode == 1) ? !pol : pol;
    exp_rc   = exp_link ? 0 : 1;
  endfunction

  typedef struct {
    logic       en;
    int         adv;
    logic [2:0] st;
    logic       mr;
    logic       pr;
    logic       lu;
    logic       fl;
    logic [7:0] rc;
  } vec_t;

  vec_t vecs[15];

  initial begin
    int n, lat, t_link, t0;
    resetb = 1'b0;

    // No-lock retrain sequence, then enable drop from FAIL and from WAIT_LOCK.
    vecs[0]  = '{1'b0,  1, ST_IDLE,      1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[1]  = '{1'b1,  1, ST_MMCM_RST,  1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[2]  = '{1'b1,  4, ST_WAIT_LOCK, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[3]  = '{1'b1, 31, ST_WAIT_LOCK, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[4]  = '{1'b1,  1, ST_MMCM_RST,  1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
    vecs[5]  = '{1'b1,  3, ST_MMCM_RST,  1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
    vecs[6]  = '{1'b1,  1, ST_WAIT_LOCK, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
    vecs[7]  = '{1'b1, 32, ST_MMCM_RST,  1'b1, 1'b0, 1'b0, 1'b0, 8'd2};
    vecs[8]  = '{1'b1, 35, ST_WAIT_LOCK, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2};
    vecs[9]  = '{1'b1,  1, ST_FAIL,      1'b1, 1'b0, 1'b0, 1'b1, 8'd2};
    vecs[10] = '{1'b1, 10, ST_FAIL,      1'b1, 1'b0, 1'b0, 1'b1, 8'd2};
    vecs[11] = '{1'b0,  1, ST_IDLE,      1'b1, 1'b0, 1'b0, 1'b0, 8'd2};
    vecs[12] = '{1'b1,  1, ST_MMCM_RST,  1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[13] = '{1'b1,  6, ST_WAIT_LOCK, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[14] = '{1'b0,  1, ST_IDLE,      1'b1, 1'b0, 1'b0, 1'b0, 8'd0};

    do_reset();
    for (int i = 0; i < 15; i++) begin
      enable = vecs[i].en;
      tick(vecs[i].adv);
      check($sformatf("vec%0d.state", i), 32'(state), 32'(vecs[i].st));
      check($sformatf("vec%0d.mmcm_reset", i), 32'(mmcm_reset), 32'(vecs[i].mr));
      check($sformatf("vec%0d.phy_resetb", i), 32'(phy_resetb), 32'(vecs[i].pr));
      check($sformatf("vec%0d.link_up", i), 32'(link_up), 32'(vecs[i].lu));
      check($sformatf("vec%0d.fail", i), 32'(fail), 32'(vecs[i].fl));
      check($sformatf("vec%0d.retry_count", i), 32'(retry_count), 32'(vecs[i].rc));
    end

    // Nominal bring-up with measured reset widths.
    do_reset();
    cfg_polarity = 1'b1; auto_polarity = 1'b1; cfg_tx_period = 8'h5A;
    enable = 1'b1;
    wait_state(ST_MMCM_RST, 4, "nom.mmcm_state");
    n = 0;
    while (mmcm_reset === 1'b1 && n < 20) begin tick(1); n++; end
    check("nom.mmcm_width", 32'(n), 32'(MMCM_N));
    check("nom.wait_lock", 32'(state), 32'(ST_WAIT_LOCK));
    tick(10);
    locked = 1'b1;
    wait_state(ST_PHY_RST, 10, "nom.phy_rst_state");
    n = 0;
    while (phy_resetb === 1'b0 && n < 20) begin tick(1); n++; end
    check("nom.phy_rst_width", 32'(n), 32'(PHYR_N));
    check("nom.search", 32'(state), 32'(ST_SEARCH));
    check("nom.md_polarity", 32'(md_polarity), 32'd1);
    check("nom.tx_period", 32'(mipi_tx_period), 32'h5A);
    tick(20);
    pulse_we(lat, t_link);
    check("nom.link_latency", 32'(lat), 32'd3);
    check("nom.link_up", 32'(link_up), 32'd1);
    check("nom.linked", 32'(state), 32'(ST_LINKED));
    check("nom.retry_count", 32'(retry_count), 32'd0);

    // Polarity flip after a silent search, then link on the flipped polarity.
    do_reset();
    bring_up(1'b0, 1'b1, 8'h11, 5);
    t0 = cyc;
    wait_state(ST_PHY_RST, 60, "flip.phy_rst_state");
    check("flip.search_len", 32'(cyc - t0), 32'(SEARCH_N));
    check("flip.md_polarity", 32'(md_polarity), 32'd1);
    n = 0;
    while (phy_resetb === 1'b0 && n < 20) begin tick(1); n++; end
    check("flip.phy_rst_width", 32'(n), 32'(PHYR_N));
    tick(5);
    pulse_we(lat, t_link);
    check("flip.link_up", 32'(link_up), 32'd1);
    check("flip.md_polarity_kept", 32'(md_polarity), 32'd1);

    // Lock loss while linked.
    locked = 1'b0;
    n = 0;
    while (lock_lost !== 1'b1 && n < 10) begin tick(1); n++; end
    check("lost.pulse_delay", 32'(n), 32'd3);
    check("lost.link_up", 32'(link_up), 32'd0);
    check("lost.mmcm_reset", 32'(mmcm_reset), 32'd1);
    check("lost.retry_count", 32'(retry_count), 32'd1);
    check("lost.md_polarity", 32'(md_polarity), 32'd0);
    check("lost.state", 32'(state), 32'(ST_MMCM_RST));
    tick(1);
    check("lost.pulse_width", 32'(lock_lost), 32'd0);

    // Link silence: re-search without touching polarity or retry count.
    do_reset();
    bring_up(1'b1, 1'b0, 8'h22, 2);
    tick(4);
    pulse_we(lat, t_link);
    check("silence.link_up", 32'(link_up), 32'd1);
    wait_state(ST_PHY_RST, 120, "silence.phy_rst_state");
    check("silence.len", 32'(cyc - t_link), 32'(LINK_N));
    check("silence.link_down", 32'(link_up), 32'd0);
    check("silence.phy_resetb", 32'(phy_resetb), 32'd0);
    check("silence.md_polarity", 32'(md_polarity), 32'd1);
    check("silence.retry_count", 32'(retry_count), 32'd0);

    // Async reset in the middle of SEARCH takes effect without a clock edge.
    do_reset();
    bring_up(1'b1, 1'b1, 8'h33, 0);
    tick(5);
    #2;
    resetb = 1'b0;
    #1;
    check("areset.state", 32'(state), 32'(ST_IDLE));
    check("areset.mmcm_reset", 32'(mmcm_reset), 32'd1);
    check("areset.phy_resetb", 32'(phy_resetb), 32'd0);
    check("areset.md_polarity", 32'(md_polarity), 32'd0);
    check("areset.tx_period", 32'(mipi_tx_period), 32'd0);
    check("areset.link_up", 32'(link_up), 32'd0);
    check("areset.fail", 32'(fail), 32'd0);
    check("areset.lock_lost", 32'(lock_lost), 32'd0);
    check("areset.retry_count", 32'(retry_count), 32'd0);
    tick(1);

    // Randomized training runs against the outcome model.
    for (int it = 0; it < 20; it++) begin
      bit pol, ap, e_link, e_pol;
      int mode, a, ld, e_rc;
      logic [7:0] tx;
      pol  = 1'($urandom_range(0, 1));
      ap   = 1'($urandom_range(0, 1));
      tx   = 8'($urandom_range(0, 255));
      ld   = $urandom_range(0, 20);
      a    = $urandom_range(0, 30);
      mode = $urandom_range(0, 2);
      model(pol, ap, mode, e_link, e_pol, e_rc);

      do_reset();
      bring_up(pol, ap, tx, ld);
      if (mode == 0) begin
        tick(a);
        pulse_we(lat, t_link);
      end else begin
        wait_leave_search(SEARCH_N + 10);
        if (ap) begin
          wait_state(ST_SEARCH, 10, $sformatf("rnd%0d.second_search", it));
          if (mode == 1) begin
            tick(a);
            pulse_we(lat, t_link);
          end else begin
            wait_leave_search(SEARCH_N + 10);
          end
        end
      end
      check($sformatf("rnd%0d.link_up", it), 32'(link_up), 32'(e_link));
      check($sformatf("rnd%0d.md_polarity", it), 32'(md_polarity), 32'(e_pol));
      check($sformatf("rnd%0d.retry_count", it), 32'(retry_count), 32'(e_rc));
      check($sformatf("rnd%0d.tx_period", it), 32'(mipi_tx_period), 32'(tx));
      check($sformatf("rnd%0d.mmcm_reset", it), 32'(mmcm_reset), 32'(!e_link));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mipi_phy_ctrl.md
Name: mipi_phy_ctrl

Overview:
Bring-up and supervision controller for the MIPI single-lane deserializer PHY. It sequences the PHY's MMCM reset and the PHY's async reset, and programs the PHY's LP-stall period. It searches for packet activity, flipping data-lane polarity when none is found, and re-trains on lock loss or link silence. Runs on the free-running system clock beside the PHY and reports link status to the register block.

Parameters:
CNT_W, 24, width of the shared timeout counter
MMCM_RST_CYCLES, 64, cycles mmcm_reset is held high per attempt
LOCK_TIMEOUT, 65536, max cycles waiting for MMCM lock
PHY_RST_CYCLES, 16, cycles phy_resetb is held low
SEARCH_TIMEOUT, 1048576, max cycles waiting for first packet per polarity
LINK_TIMEOUT, 4194304, max idle cycles in LINKED before re-search
MAX_RETRIES, 8, full MMCM retrain attempts before FAIL

Ports:
clk  in  1  system clock
resetb  in  1  async active-low reset
enable  in  1  level; 1 = train and hold link, 0 = hold PHY in reset
auto_polarity  in  1  1 = allow polarity flip during search
cfg_polarity  in  1  initial md_polarity
cfg_tx_period  in  8  LP-stall period for the PHY
locked  in  1  MMCM lock from PHY (async)
phy_we  in  1  PHY byte-valid (PHY clock domain, async here)
mmcm_reset  out  1  to PHY mmcm_reset
phy_resetb  out  1  to PHY resetb
md_polarity  out  1  to PHY md_polarity
mipi_tx_period  out  8  to PHY mipi_tx_period
link_up  out  1  1 in LINKED
fail  out  1  1 in FAIL
lock_lost  out  1  one-cycle pulse on lock drop in LINKED
retry_count  out  8  full retrains since enable rose, saturating
state  out  3  current FSM state

Behaviour:
- Reset values: mmcm_reset=1, phy_resetb=0, md_polarity=0, mipi_tx_period=0, link_up=0, fail=0, lock_lost=0, retry_count=0, state=IDLE, counter=0.
- locked and phy_we pass through 2-flop synchronizers (locked_s, we_s). Activity = rising edge of we_s. A PHY packet holds we high for at least 4 PHY clocks, so this is sufficient.
- States, encoded 0-6: IDLE, MMCM_RST, WAIT_LOCK, PHY_RST, SEARCH, LINKED, FAIL.
- IDLE: mmcm_reset=1, phy_resetb=0. When enable=1: latch md_polarity<=cfg_polarity, mipi_tx_period<=cfg_tx_period, retry_count<=0, pol_flipped<=0, go to MMCM_RST.
- MMCM_RST: mmcm_reset=1 for exactly MMCM_RST_CYCLES cycles, then go to WAIT_LOCK with mmcm_reset=0.
- WAIT_LOCK: phy_resetb=0. If locked_s=1, go to PHY_RST. If the counter reaches LOCK_TIMEOUT, take the retry path.
- PHY_RST: phy_resetb=0 for PHY_RST_CYCLES cycles, then phy_resetb=1 and go to SEARCH.
- SEARCH:
  - Activity -> LINKED.
  - locked_s=0 -> retry path.
  - Timeout with auto_polarity=1 and pol_flipped=0 -> toggle md_polarity, set pol_flipped=1, go to PHY_RST.
  - Any other timeout -> retry path.
- LINKED: link_up=1.
  - Each activity clears the counter.
  - locked_s falls -> lock_lost pulse, retry path.
  - Counter reaches LINK_TIMEOUT -> link_up=0, pol_flipped=0, go to PHY_RST (polarity kept).
- Retry path: if retry_count+1 == MAX_RETRIES -> FAIL. Otherwise retry_count++, pol_flipped=0, md_polarity<=cfg_polarity, go to MMCM_RST.
- FAIL: fail=1, mmcm_reset=1, phy_resetb=0; stays until enable=0.
- enable=0 in any state -> IDLE on the next edge; outputs take their IDLE values (fail clears). This has priority over all other transitions.
- Counter: single CNT_W counter, cleared on every state entry; increments with saturation. Each timeout fires when count == N-1, so the state lasts exactly N cycles.
- Outputs are registered. mmcm_reset and phy_resetb are glitch-free and change only on clk edges.
- mipi_tx_period and md_polarity change only in IDLE, on polarity flip, or on retry. They are stable while phy_resetb=1, except across a flip, which always passes through PHY_RST.
- Async reset mid-operation forces the reset values immediately.

Decomposition:
- Package mipi_phy_ctrl_pkg: state encodings ST_IDLE..ST_FAIL (3 bits), default timeout constants.
- One sub-module, mipi_sync2: 2-flop synchronizer with async active-low reset. Instantiated twice (locked, phy_we).

Test Plan:
Use small parameters: MMCM_RST_CYCLES=4, LOCK_TIMEOUT=32, PHY_RST_CYCLES=3, SEARCH_TIMEOUT=50, LINK_TIMEOUT=100, MAX_RETRIES=3.
- Nominal: enable=1, locked rises 10 cycles after mmcm_reset falls, phy_we pulse 20 cycles after phy_resetb=1 -> mmcm_reset high exactly 4 cycles, phy_resetb low 3 cycles, link_up=1 within 3 cycles of the pulse, retry_count=0.
- Polarity flip: cfg_polarity=0, auto_polarity=1, no activity for 50 cycles -> md_polarity=1, phy_resetb low 3 cycles; then phy_we pulse -> link_up=1, md_polarity stays 1.
- No lock: locked held 0 -> three attempts, each 4+32 cycles; retry_count counts 1, 2; then fail=1, state=6. enable=0 -> state=0, fail=0.
- Lock loss: in LINKED, drop locked -> one-cycle lock_lost pulse ~2 cycles later, link_up=0, mmcm_reset=1, retry_count=1.
- Link silence: in LINKED, no phy_we for 100 cycles -> link_up=0, state=PHY_RST, md_polarity unchanged, retry_count unchanged.
- Async reset asserted mid-SEARCH, and enable=0 mid-WAIT_LOCK -> all outputs return to reset/IDLE values; mmcm_reset=1 without glitch.
